// File: rtl/bistable_bus_qualifier.sv
// Debounce/qualify stage for the skew-prone level bus from bistable_domain_cross.
// A new bus value is committed only after holding steady, then announced with one-cycle edge pulses.
module bistable_bus_qualifier #(
    parameter int                 WIDTH         = 2,
    parameter int                 STABLE_CYCLES = 2,
    parameter logic [WIDTH-1:0]   INIT          = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= INIT;
            cnt_q     <= '0;
            out_q     <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    // Returning to the committed value beats everything else, so a glitch never reaches out.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        rise_d    = '0;
        fall_d    = '0;
        changed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in != out_q) begin
                    state_d = SETTLE;
                    cand_d  = in;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (in == out_q) begin
                    state_d = IDLE;
                end else if (in != cand_q) begin
                    cand_d = in;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    out_d     = cand_q;
                    rise_d    = cand_q & ~out_q;
                    fall_d    = ~cand_q & out_q;
                    changed_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;
    assign busy    = (state_q == SETTLE);

endmodule

// File: tb/tb_bistable_bus_qualifier.sv
// Bench for bistable_bus_qualifier: directed vector table plus random stimulus against a run-length model.
// Two instances (STABLE_CYCLES 2 and 1) share the same clock, reset and input bus.
module tb_bistable_bus_qualifier;

    typedef struct {
        logic       r;
        logic [1:0] v;
        logic [7:0] e;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] in_s;

    logic [1:0] out_a, rise_a, fall_a;
    logic       changed_a, busy_a;
    logic [1:0] out_b, rise_b, fall_b;
    logic       changed_b, busy_b;

    int checks;
    int errors;

    vec_t vecs[$];

    // Model state per instance: index 0 is STABLE_CYCLES=2, index 1 is STABLE_CYCLES=1
    int         s_cyc[2];
    logic [1:0] m_out[2];
    logic [1:0] m_last[2];
    int         m_run[2];
    logic [7:0] m_exp[2];

    bistable_bus_qualifier #(.WIDTH(2), .STABLE_CYCLES(2), .INIT(2'b00)) dut_a (
        .clk(clk), .rst(rst), .in(in_s),
        .out(out_a), .rise(rise_a), .fall(fall_a), .changed(changed_a), .busy(busy_a)
    );

    bistable_bus_qualifier #(.WIDTH(2), .STABLE_CYCLES(1), .INIT(2'b00)) dut_b (
        .clk(clk), .rst(rst), .in(in_s),
        .out(out_b), .rise(rise_b), .fall(fall_b), .changed(changed_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pack(input logic [1:0] o, input logic [1:0] ri,
                                        input logic [1:0] fa, input logic ch, input logic bu);
        return {o, ri, fa, ch, bu};
    endfunction

    // A value is committed once it differs from out and has been sampled on STABLE_CYCLES+1 consecutive edges.
    task automatic model_edge(input int k, input logic r, input logic [1:0] v);
        logic [1:0] old;
        logic       commit;
        if (r) begin
            m_out[k] = 2'b00;
            m_run[k] = 0;
            m_exp[k] = pack(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        end else begin
            if (m_run[k] > 0 && v == m_last[k]) m_run[k] = m_run[k] + 1;
            else m_run[k] = 1;
            m_last[k] = v;
            old = m_out[k];
            commit = (v != old) && (m_run[k] >= s_cyc[k] + 1);
            if (commit) begin
                m_out[k] = v;
                m_exp[k] = pack(v, v & ~old, ~v & old, 1'b1, 1'b0);
            end else begin
                m_exp[k] = pack(old, 2'b00, 2'b00, 1'b0, v != old);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] v);
        rst  = r;
        in_s = v;
        @(posedge clk);
        model_edge(0, r, v);
        model_edge(1, r, v);
        #1;
    endtask

    task automatic checkOutput(input string name, input int k, input logic [7:0] expv);
        logic [7:0] act;
        act = (k == 0) ? pack(out_a, rise_a, fall_a, changed_a, busy_a)
                       : pack(out_b, rise_b, fall_b, changed_b, busy_b);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: {out,rise,fall,changed,busy} got %b expected %b",
                     name, k, act, expv);
        end
    endtask

    task automatic check_models(input string name);
        checkOutput(name, 0, m_exp[0]);
        checkOutput(name, 1, m_exp[1]);
    endtask

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] o,
                       input logic [1:0] ri, input logic [1:0] fa, input logic ch, input logic bu);
        vec_t t;
        t.r = r;
        t.v = v;
        t.e = pack(o, ri, fa, ch, bu);
        vecs.push_back(t);
    endtask

    initial begin
        logic [1:0] v;
        logic       r;
        checks   = 0;
        errors   = 0;
        s_cyc[0] = 2;
        s_cyc[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = 2'b00;
            m_last[k] = 2'b00;
            m_run[k]  = 0;
            m_exp[k]  = 8'h00;
        end
        rst  = 1'b1;
        in_s = 2'b00;

        // Expected values for the STABLE_CYCLES=2 instance
        for (int i = 0; i < 3; i++) add(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1, 0);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1);
        add(0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1, 0);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1);
        add(0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1, 0);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0);

        $display("[TB] directed table, %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].v);
            checkOutput($sformatf("table[%0d]", i), 0, vecs[i].e);
            check_models($sformatf("table_model[%0d]", i));
        end

        // STABLE_CYCLES=1: toggling between two values that both differ from out never commits
        $display("[TB] short-window sequences");
        applyStimulus(1, 2'b00);
        applyStimulus(1, 2'b00);
        check_models("reset_b");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, (i % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("toggle_0110[%0d]", i), 1, pack(2'b00, 2'b00, 2'b00, 0, 1));
            check_models("toggle_0110_model");
        end
        applyStimulus(0, 2'b11);
        checkOutput("step_b_edge1", 1, pack(2'b00, 2'b00, 2'b00, 0, 1));
        check_models("step_b_edge1_model");
        applyStimulus(0, 2'b11);
        checkOutput("step_b_edge2", 1, pack(2'b11, 2'b11, 2'b00, 1, 0));
        check_models("step_b_edge2_model");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, (i % 2 == 0) ? 2'b00 : 2'b11);
            checkOutput($sformatf("toggle_0011[%0d]", i), 1,
                        pack(2'b11, 2'b00, 2'b00, 0, (i % 2 == 0)));
            check_models("toggle_0011_model");
        end

        // Random stimulus with held values and occasional reset
        $display("[TB] random phase");
        v = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) v = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 63) == 0);
            applyStimulus(r, v);
            check_models($sformatf("random[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
